seg_scan_driver: RTL and testbench
==================================

Name: seg_scan_driver

Overview:
- Time-multiplexed scan driver for the 7-segment display.
- Generates the 3-bit `scan` index consumed by the segment-mapping stage, and registers that stage's 8-bit segment pattern for the selected digit.
- Drives the active-low digit anodes, with a blanking gap between digits (anti-ghosting) and per-digit blink.
- Sits between the segment-mapping logic and the board's digit/segment pins.

Parameters:
- NDIG, 4, number of digits scanned (1..8); `scan` counts 0..NDIG-1.
- DIGIT_CYCLES, 100000, clk cycles a digit is lit (>=1).
- BLANK_CYCLES, 2000, clk cycles all anodes are off before each digit (>=1).
- BLINK_CYCLES, 25000000, clk cycles per blink half-period (>=1).

Ports:
- clk, input, 1, system clock.
- rst, input, 1, synchronous active-high reset.
- en, input, 1, display enable; 0 forces display dark.
- seg_in, input, 8, segment pattern for the current `scan` (combinational from mapping stage, active-low segments).
- le, input, 8, per-digit blink enable; bit i refers to digit i.
- scan, output, 3, current digit index to the mapping stage.
- an, output, 8, digit anodes, active-low; bits >= NDIG always 1.
- seg_out, output, 8, registered segment drive, active-low.

Behaviour:
- Interface: one clock `clk`; reset `rst` is synchronous and active-high.
- All outputs are registered.
- Reset values:
  - scan=0, an=8'hFF, seg_out=8'hFF.
  - state=BLANK, dig_cnt=0, blink_cnt=0, blink_ph=0.
- FSM states:
  - OFF:
    - an=FF, seg_out=FF, scan held.
    - en=1 -> BLANK with dig_cnt=0.
  - BLANK:
    - an=FF, seg_out=FF; dig_cnt increments.
    - At dig_cnt==BLANK_CYCLES-1 -> SHOW with dig_cnt=0.
    - On that same edge: seg_out<=seg_in, an<=~(1<<scan), gated by blink (below).
  - SHOW:
    - seg_out holds the captured value (not re-sampled); dig_cnt increments.
    - an is re-evaluated every cycle from the blink gate.
    - At dig_cnt==DIGIT_CYCLES-1 -> BLANK with dig_cnt=0.
    - On that same edge: an<=FF, seg_out<=FF, scan<=(scan==NDIG-1)?0:scan+1.
- Scan change timing: scan changes only on SHOW->BLANK, so seg_in has >=BLANK_CYCLES cycles to settle before capture.
- Digit timing:
  - A digit is lit exactly DIGIT_CYCLES cycles, preceded by exactly BLANK_CYCLES dark cycles.
  - Full frame = NDIG*(DIGIT_CYCLES+BLANK_CYCLES).
- en=0:
  - In any state, the next edge -> OFF with an=FF, seg_out=FF, dig_cnt=0.
  - en has priority over counter expiry on the same edge.
- Blink:
  - blink_cnt is free-running in all states and wraps at BLINK_CYCLES-1, toggling blink_ph on wrap.
  - In SHOW, if le[scan]==1 and blink_ph==1, then an=FF; seg_out is unaffected.
- Reset mid-operation:
  - rst has priority over en and counters.
  - It immediately restores the reset values; the first digit shown after reset is digit 0.
- Width rules:
  - Counters are sized by $clog2 of their maximum count.
  - No counter exceeds its terminal value; none overflow.

Decomposition:
- Shared display package holds:
  - state encoding (OFF, BLANK, SHOW);
  - SEG_DARK=8'hFF and AN_DARK=8'hFF;
  - an index-to-one-hot-low decode function.
- One sub-module, seg_blink_gen: the free-running BLINK_CYCLES divider producing blink_ph.
  - It is reusable by other display stages.
- FSM, dig_cnt and scan stay in seg_scan_driver.

Test Plan:
Test parameters: NDIG=4, DIGIT_CYCLES=8, BLANK_CYCLES=2, BLINK_CYCLES=20.
1. Reset then en=1, seg_in=8'hC0 constant.
   - Cycles 1-2 after reset: an=FF.
   - Cycle 3: an=FE, seg_out=C0 for 8 cycles, then an=FF for 2 cycles.
   - Then an=FD with scan=1.
2. Wrap and frame timing.
   - Frame=40 cycles; scan sequence 0,1,2,3,0.
   - an sequence FE,FD,FB,F7,FE.
   - an[7:4] stay 1 throughout.
3. Capture stability: change seg_in from A4 to 99 mid-SHOW.
   - seg_out stays A4 until the next digit capture.
4. en dropped mid-SHOW at scan=2.
   - Next cycle: an=FF, seg_out=FF, scan stays 2.
   - Re-assert en: 2 dark cycles, then digit 2 is lit.
5. Blink with le=8'h02.
   - While blink_ph=1 (cycles 20-39 after reset), digit 1's slot shows an=FF.
   - Digits 0, 2 and 3 are unaffected.
   - While blink_ph=0, digit 1 shows an=FD.
6. rst asserted mid-SHOW at scan=3 while en=0 is simultaneously requested.
   - Next cycle: reset values (scan=0, an=FF, state BLANK).
   - The rst edge itself does not enter OFF.

Source files
------------

// File: rtl/seg_scan_driver_pkg.sv
// Shared definitions for the 7-segment display path: scan FSM encoding,
// dark patterns and the digit-index to active-low anode decode.
package seg_scan_driver_pkg;

    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_BLANK = 2'd1,
        ST_SHOW  = 2'd2
    } scan_state_t;

    localparam logic [7:0] SEG_DARK = 8'hFF;
    localparam logic [7:0] AN_DARK  = 8'hFF;

    // One-hot-low anode select: only the addressed digit is driven low.
    function automatic logic [7:0] idx_to_an(input logic [2:0] idx);
        return ~(8'b1 << idx);
    endfunction

endpackage

// File: rtl/seg_blink_gen.sv
// Free-running blink divider: blink_ph toggles every BLINK_CYCLES clocks.
module seg_blink_gen #(
    parameter int BLINK_CYCLES = 25000000
) (
    input  logic clk,
    input  logic rst,
    output logic o_blink_ph
);

    localparam int BCW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
    localparam logic [BCW-1:0] BLINK_LAST = BCW'(BLINK_CYCLES - 1);

    logic [BCW-1:0] r_cnt;
    logic           r_ph;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
            r_ph  <= 1'b0;
        end else if (r_cnt == BLINK_LAST) begin
            r_cnt <= '0;
            r_ph  <= ~r_ph;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_blink_ph = r_ph;

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed 7-segment scan driver: blank gap, digit capture and lit
// period per digit, with per-digit blink gating of the anodes.
module seg_scan_driver
    import seg_scan_driver_pkg::*;
#(
    parameter int NDIG         = 4,
    parameter int DIGIT_CYCLES = 100000,
    parameter int BLANK_CYCLES = 2000,
    parameter int BLINK_CYCLES = 25000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [7:0]  seg_in,
    input  logic [7:0]  le,
    output logic [2:0]  scan,
    output logic [7:0]  an,
    output logic [7:0]  seg_out,
    output scan_state_t dbg_state
);

    localparam int DIG_MAX = (DIGIT_CYCLES > BLANK_CYCLES) ? DIGIT_CYCLES : BLANK_CYCLES;
    localparam int DCW     = (DIG_MAX > 1) ? $clog2(DIG_MAX) : 1;
    localparam logic [DCW-1:0] DIG_LAST   = DCW'(DIGIT_CYCLES - 1);
    localparam logic [DCW-1:0] BLANK_LAST = DCW'(BLANK_CYCLES - 1);
    localparam logic [2:0]     SCAN_LAST  = 3'(NDIG - 1);

    scan_state_t    r_state;
    logic [DCW-1:0] r_dig_cnt;
    logic [2:0]     r_scan;
    logic [7:0]     r_an;
    logic [7:0]     r_seg;

    scan_state_t    w_state_nxt;
    logic [DCW-1:0] w_cnt_nxt;
    logic [2:0]     w_scan_nxt;
    logic [7:0]     w_an_nxt;
    logic [7:0]     w_seg_nxt;
    logic           w_blink_ph;
    logic           w_hide;

    seg_blink_gen #(
        .BLINK_CYCLES(BLINK_CYCLES)
    ) u_blink (
        .clk       (clk),
        .rst       (rst),
        .o_blink_ph(w_blink_ph)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_BLANK;
            r_dig_cnt <= '0;
            r_scan    <= '0;
            r_an      <= AN_DARK;
            r_seg     <= SEG_DARK;
        end else begin
            r_state   <= w_state_nxt;
            r_dig_cnt <= w_cnt_nxt;
            r_scan    <= w_scan_nxt;
            r_an      <= w_an_nxt;
            r_seg     <= w_seg_nxt;
        end
    end

    // Disable wins over any counter expiry; scan only advances on SHOW->BLANK.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_dig_cnt;
        w_scan_nxt  = r_scan;
        if (!en) begin
            w_state_nxt = ST_OFF;
            w_cnt_nxt   = '0;
        end else begin
            case (r_state)
                ST_OFF: begin
                    w_state_nxt = ST_BLANK;
                    w_cnt_nxt   = '0;
                end
                ST_BLANK: begin
                    if (r_dig_cnt == BLANK_LAST) begin
                        w_state_nxt = ST_SHOW;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_dig_cnt + 1'b1;
                    end
                end
                ST_SHOW: begin
                    if (r_dig_cnt == DIG_LAST) begin
                        w_state_nxt = ST_BLANK;
                        w_cnt_nxt   = '0;
                        w_scan_nxt  = (r_scan == SCAN_LAST) ? 3'd0 : r_scan + 3'd1;
                    end else begin
                        w_cnt_nxt = r_dig_cnt + 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = ST_OFF;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    assign w_hide = le[r_scan] & w_blink_ph;

    // Segments are captured once at BLANK->SHOW; anodes re-gated every lit cycle.
    always_comb begin
        w_an_nxt  = AN_DARK;
        w_seg_nxt = SEG_DARK;
        if (en) begin
            if (r_state == ST_BLANK && r_dig_cnt == BLANK_LAST) begin
                w_seg_nxt = seg_in;
                w_an_nxt  = w_hide ? AN_DARK : idx_to_an(r_scan);
            end else if (r_state == ST_SHOW && r_dig_cnt != DIG_LAST) begin
                w_seg_nxt = r_seg;
                w_an_nxt  = w_hide ? AN_DARK : idx_to_an(r_scan);
            end
        end
    end

    assign scan      = r_scan;
    assign an        = r_an;
    assign seg_out   = r_seg;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Randomized scoreboard bench for seg_scan_driver against a frame-position model.
module tb_seg_scan_driver;
    import seg_scan_driver_pkg::*;

    localparam int NDIG = 4;
    localparam int DC   = 8;
    localparam int BC   = 2;
    localparam int BL   = 20;
    localparam int SLOT = BC + DC;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic [7:0]  seg_in = 8'hFF;
    logic [7:0]  le = 8'h00;
    logic [2:0]  scan;
    logic [7:0]  an;
    logic [7:0]  seg_out;
    scan_state_t dbg_state;

    seg_scan_driver #(
        .NDIG(NDIG), .DIGIT_CYCLES(DC), .BLANK_CYCLES(BC), .BLINK_CYCLES(BL)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .seg_in(seg_in), .le(le),
        .scan(scan), .an(an), .seg_out(seg_out), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    logic [18:0] exp_q[$];
    int checks = 0;
    int failures = 0;
    bit mon_on = 1'b0;

    // Reference: position m_t inside a (blank+lit) slot, current digit, cycles since reset.
    int         m_t = 0;
    int         m_digit = 0;
    int         m_bt = 0;
    bit         m_on = 1'b1;
    logic [7:0] m_seg = 8'hFF;

    task automatic model_step();
        logic [7:0] e_an;
        logic [7:0] e_seg;
        logic [2:0] e_scan;
        bit ph;
        e_an  = 8'hFF;
        e_seg = 8'hFF;
        if (rst) begin
            m_t = 0; m_digit = 0; m_on = 1'b1; m_bt = 0;
        end else begin
            ph = ((m_bt / BL) % 2) == 1;
            m_bt++;
            if (!en) begin
                m_on = 1'b0;
            end else if (!m_on) begin
                m_on = 1'b1;
                m_t = 0;
            end else begin
                m_t++;
                if (m_t == SLOT) begin
                    m_t = 0;
                    m_digit = (m_digit + 1) % NDIG;
                end
                if (m_t >= BC) begin
                    if (m_t == BC) m_seg = seg_in;
                    e_seg = m_seg;
                    e_an  = (le[m_digit] && ph) ? 8'hFF : ~(8'b1 << m_digit);
                end
            end
        end
        e_scan = m_digit[2:0];
        exp_q.push_back({e_scan, e_an, e_seg});
    endtask

    task automatic tick(input logic r, input logic e, input logic [7:0] s, input logic [7:0] l);
        @(negedge clk);
        rst = r; en = e; seg_in = s; le = l;
        model_step();
        mon_on = 1'b1;
    endtask

    task automatic check_val(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    always @(posedge clk) begin
        if (mon_on) begin
            #1;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL underflow at %0t: got empty queue expected entry", $time);
            end else begin
                logic [18:0] e;
                e = exp_q.pop_front();
                check_val("scan", {5'd0, scan}, {5'd0, e[18:16]});
                check_val("an", an, e[15:8]);
                check_val("seg_out", seg_out, e[7:0]);
            end
        end
    end

    // Runs with en=1 until the model sits mid-SHOW on the requested digit.
    task automatic run_to_show(input int digit, input string name);
        int n;
        n = 0;
        while (!(m_on && m_digit == digit && m_t >= BC + 3) && n < 200) begin
            tick(1'b0, 1'b1, 8'($urandom_range(0, 255)), 8'h00);
            n++;
        end
        checks++;
        if (n >= 200) begin
            failures++;
            $display("FAIL %s: got no SHOW of digit %0d expected within 200 cycles", name, digit);
        end
    endtask

    initial begin
        // Reset, then constant C0 for a bit over one frame.
        tick(1'b1, 1'b0, 8'hC0, 8'h00);
        tick(1'b0, 1'b1, 8'hC0, 8'h00);
        check_val("reset_state", {6'd0, dbg_state}, {6'd0, ST_BLANK});
        for (int i = 0; i < 50; i++) tick(1'b0, 1'b1, 8'hC0, 8'h00);
        // Capture stability: seg_in changes after capture within each slot.
        for (int i = 0; i < 2 * NDIG * SLOT; i++)
            tick(1'b0, 1'b1, (m_t < BC + 3) ? 8'hA4 : 8'h99, 8'h00);
        // Blink on digit 1 from reset so blink phase lines up with cycle count.
        tick(1'b1, 1'b0, 8'hFF, 8'h02);
        for (int i = 0; i < 120; i++) tick(1'b0, 1'b1, 8'($urandom_range(0, 255)), 8'h02);
        // en dropped mid-SHOW on digit 2, then re-asserted.
        run_to_show(2, "reach_digit2");
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 8'h5A, 8'h00);
        for (int i = 0; i < 12; i++) tick(1'b0, 1'b1, 8'h5A, 8'h00);
        // rst together with en=0 mid-SHOW on digit 3: reset wins.
        run_to_show(3, "reach_digit3");
        tick(1'b1, 1'b0, 8'h00, 8'h00);
        tick(1'b0, 1'b1, 8'h00, 8'h00);
        check_val("rst_over_en", {6'd0, dbg_state}, {6'd0, ST_BLANK});
        for (int i = 0; i < 20; i++) tick(1'b0, 1'b1, 8'h00, 8'h00);
        // Random en, le, seg_in with occasional resets.
        for (int i = 0; i < 600; i++)
            tick(($urandom_range(0, 99) == 0), ($urandom_range(0, 15) != 0),
                 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
        @(posedge clk);
        #3;
        mon_on = 1'b0;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d entries left expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
